// File: rtl/qimag_serial_adder_if.sv
// Handshake and operand/result bundle for qimag_serial_adder.
// op_sub is present only when QIMAG_SUB_EN is defined.
interface qimag_serial_adder_if #(
    parameter int NDIGITS = 8
);
    localparam int RDIGITS = NDIGITS + 4;

    logic                   in_valid;
    logic                   in_ready;
    logic [2*NDIGITS-1:0]   a;
    logic [2*NDIGITS-1:0]   b;
`ifdef QIMAG_SUB_EN
    logic                   op_sub;
`endif
    logic                   out_valid;
    logic                   out_ready;
    logic [2*RDIGITS-1:0]   sum;
    logic                   busy;

`ifdef QIMAG_SUB_EN
    modport master (output in_valid, a, b, op_sub, out_ready,
                    input  in_ready, out_valid, sum, busy);
    modport slave  (input  in_valid, a, b, op_sub, out_ready,
                    output in_ready, out_valid, sum, busy);
`else
    modport master (output in_valid, a, b, out_ready,
                    input  in_ready, out_valid, sum, busy);
    modport slave  (input  in_valid, a, b, out_ready,
                    output in_ready, out_valid, sum, busy);
`endif
endinterface

// File: rtl/qimag_serial_adder.sv
// Digit-serial quater-imaginary (base 2i) adder, one digit per cycle, LSD first.
// Define QIMAG_SUB_EN to add op_sub (A-B) on the interface.
module qimag_serial_adder #(
    parameter int NDIGITS = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    qimag_serial_adder_if.slave   bus
);
    localparam int RDIGITS = NDIGITS + 4;
    localparam int CW      = $clog2(RDIGITS);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t                  state_q, state_d;
    logic [2*RDIGITS-1:0]    a_q, a_d;
    logic [2*RDIGITS-1:0]    b_q, b_d;
    logic [2*RDIGITS-1:0]    sum_q, sum_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    // Signed carry delay line: c0 lands on the current digit, c1 on the next one.
    logic signed [1:0]       c0_q, c0_d;
    logic signed [1:0]       c1_q, c1_d;
`ifdef QIMAG_SUB_EN
    logic                    sub_q, sub_d;
`endif

    logic signed [3:0]       da, db, dc, t;
    logic signed [1:0]       c_new;

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        cnt_d   = cnt_q;
        c0_d    = c0_q;
        c1_d    = c1_q;
`ifdef QIMAG_SUB_EN
        sub_d   = sub_q;
`endif
        da      = {2'b00, a_q[1:0]};
        db      = {2'b00, b_q[1:0]};
        dc      = {{2{c0_q[1]}}, c0_q};
        t       = '0;
        c_new   = '0;

        case (state_q)
            S_IDLE: begin
                if (bus.in_valid) begin
                    a_d     = {{(2*(RDIGITS-NDIGITS)){1'b0}}, bus.a};
                    b_d     = {{(2*(RDIGITS-NDIGITS)){1'b0}}, bus.b};
`ifdef QIMAG_SUB_EN
                    sub_d   = bus.op_sub;
`endif
                    c0_d    = '0;
                    c1_d    = '0;
                    cnt_d   = '0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
`ifdef QIMAG_SUB_EN
                t = sub_q ? (da - db + dc) : (da + db + dc);
`else
                t = da + db + dc;
`endif
                // (2i)^2 = -4, so an excess of 4 here is worth -1 two places up.
                if (t >= 4'sd4)      c_new = -2'sd1;
                else if (t < 4'sd0)  c_new = 2'sd1;
                // t-4 and t+4 share the low two bits of t.
                sum_d[{cnt_q, 1'b0} +: 2] = t[1:0];
                a_d   = a_q >> 2;
                b_d   = b_q >> 2;
                c0_d  = c1_q;
                c1_d  = c_new;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CW'(RDIGITS - 1)) state_d = S_DONE;
            end
            S_DONE: begin
                if (bus.out_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            cnt_q   <= '0;
            c0_q    <= '0;
            c1_q    <= '0;
`ifdef QIMAG_SUB_EN
            sub_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            cnt_q   <= cnt_d;
            c0_q    <= c0_d;
            c1_q    <= c1_d;
`ifdef QIMAG_SUB_EN
            sub_q   <= sub_d;
`endif
        end
    end

    assign bus.in_ready  = (state_q == S_IDLE);
    assign bus.busy      = (state_q == S_RUN);
    assign bus.out_valid = (state_q == S_DONE);
    assign bus.sum       = sum_q;

endmodule

// File: tb/tb_qimag_serial_adder.sv
// Randomized self-checking bench for qimag_serial_adder against a complex-value model.
// Build with QIMAG_SUB_EN defined to also exercise subtraction.
module tb_qimag_serial_adder;
    localparam int NDIGITS = 8;
    localparam int RDIGITS = NDIGITS + 4;
    localparam int AW      = 2 * NDIGITS;
    localparam int SW      = 2 * RDIGITS;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    qimag_serial_adder_if #(.NDIGITS(NDIGITS)) bus ();

    qimag_serial_adder #(.NDIGITS(NDIGITS)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_total = 0;
    int n_bad   = 0;

    task automatic check(input string tag, input longint got, input longint exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    // Complex value of a digit string: sum of d_k * (2i)^k.
    task automatic decode(input logic [SW-1:0] d, output longint re, output longint im);
        longint pr, pi, tmp;
        re = 0; im = 0; pr = 1; pi = 0;
        for (int k = 0; k < RDIGITS; k++) begin
            re += longint'(d[2*k +: 2]) * pr;
            im += longint'(d[2*k +: 2]) * pi;
            tmp = pr;
            pr  = -2 * pi;
            pi  = 2 * tmp;
        end
    endtask

    task automatic start_op(input logic [AW-1:0] a, input logic [AW-1:0] b, input logic sub);
        @(negedge clk);
        check("in_ready_before_accept", longint'(bus.in_ready), 1);
        bus.in_valid = 1'b1;
        bus.a        = a;
        bus.b        = b;
`ifdef QIMAG_SUB_EN
        bus.op_sub   = sub;
`endif
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.a        = AW'($urandom);
        bus.b        = AW'($urandom);
    endtask

    // Counts clock edges after the accept edge until out_valid is seen.
    task automatic wait_done(output int edges);
        edges = 0;
        while (!bus.out_valid && edges < 100) begin
            @(posedge clk);
            #1;
            edges++;
        end
    endtask

    task automatic handshake();
        @(negedge clk);
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        check("out_valid_after_hs", longint'(bus.out_valid), 0);
        check("in_ready_after_hs", longint'(bus.in_ready), 1);
    endtask

    // Full operation checked against the complex-arithmetic model.
    task automatic run_checked(input string tag, input logic [AW-1:0] a, input logic [AW-1:0] b,
                               input logic sub, output logic [SW-1:0] s);
        int     edges;
        longint ar, ai, br, bi, sr, si;
        start_op(a, b, sub);
        wait_done(edges);
        check({tag, "_latency"}, edges, RDIGITS);
        s = bus.sum;
        decode(SW'(a), ar, ai);
        decode(SW'(b), br, bi);
        decode(s, sr, si);
        check({tag, "_re"}, sr, sub ? ar - br : ar + br);
        check({tag, "_im"}, si, sub ? ai - bi : ai + bi);
        check({tag, "_carry_zero"}, longint'({dut.c0_q, dut.c1_q}), 0);
        handshake();
    endtask

    initial begin
        logic [SW-1:0] s, held;
        logic [AW-1:0] ra, rb;
        logic          rs;
        int            edges;

        bus.in_valid  = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.out_ready = 1'b0;
`ifdef QIMAG_SUB_EN
        bus.op_sub    = 1'b0;
`endif
        #12;
        check("rst_in_ready", longint'(bus.in_ready), 1);
        check("rst_out_valid", longint'(bus.out_valid), 0);
        check("rst_busy", longint'(bus.busy), 0);
        check("rst_sum", longint'(bus.sum), 0);
        @(negedge clk);
        rst = 1'b0;

        run_checked("add1", AW'(1), AW'(1), 1'b0, s);
        check("add1_digits", longint'(s), 2);
        run_checked("carry", AW'(2), AW'(2), 1'b0, s);
        check("carry_digits", longint'(s), 'h130);
        run_checked("odd", AW'(4), AW'(4), 1'b0, s);
        check("odd_digits", longint'(s), 'h8);
        run_checked("worst", {AW{1'b1}}, {AW{1'b1}}, 1'b0, s);

        // Backpressure: result and flags hold while out_ready stays low.
        start_op(AW'($urandom), AW'($urandom), 1'b0);
        wait_done(edges);
        check("bp_latency", edges, RDIGITS);
        held = bus.sum;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_out_valid", longint'(bus.out_valid), 1);
            check("bp_sum_stable", longint'(bus.sum), longint'(held));
            check("bp_in_ready", longint'(bus.in_ready), 0);
        end
        handshake();

        // Reset with digit 4 in flight aborts immediately.
        start_op(AW'($urandom), AW'($urandom), 1'b0);
        repeat (4) @(posedge clk);
        #1;
        check("mid_busy", longint'(bus.busy), 1);
        rst = 1'b1;
        #1;
        check("abort_in_ready", longint'(bus.in_ready), 1);
        check("abort_busy", longint'(bus.busy), 0);
        check("abort_out_valid", longint'(bus.out_valid), 0);
        check("abort_sum", longint'(bus.sum), 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_in_ready", longint'(bus.in_ready), 1);

`ifdef QIMAG_SUB_EN
        run_checked("sub_m1", AW'(0), AW'(1), 1'b1, s);
        check("sub_m1_digits", longint'(s), 'h13);
        ra = AW'($urandom);
        run_checked("sub_self", ra, ra, 1'b1, s);
        check("sub_self_digits", longint'(s), 0);
`endif

        for (int i = 0; i < 20; i++) begin
            ra = AW'($urandom);
            rb = AW'($urandom);
`ifdef QIMAG_SUB_EN
            rs = 1'($urandom_range(0, 1));
`else
            rs = 1'b0;
`endif
            run_checked("rand", ra, rb, rs, s);
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
